// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared constants and FSM encoding for the UART FIFO sequencer
package fifo_uart_pkg;
   localparam int FIFO_DEPTH   = 16;
   localparam int MAX_BURST    = 4;
   localparam int CNT_WIDTH    = 5;
   localparam int CLKS_PER_BIT = 2600;
   localparam int FLUSH_CYCLES = 10 * CLKS_PER_BIT;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      LOAD    = 2'd2,
      WAIT_TX = 2'd3
   } state_t;
   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction
endpackage

// File: rtl/fifo_xfer_scheduler_flush_timer.sv
// flush_timer: saturating up-counter with clear/enable and an expired flag
module flush_timer #(
   parameter int MAX = 26000,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [W-1:0] cnt_q, cnt_d;
   assign expired = cnt_q == W'(MAX);
   always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/fifo_xfer_scheduler.sv
// fifo_xfer_scheduler: RX write strobes and burst pop/TX launch sequencing for the UART FIFO
module fifo_xfer_scheduler
   import fifo_uart_pkg::*;
#(
   parameter int DEPTH         = FIFO_DEPTH,
   parameter int BURST         = MAX_BURST,
   parameter int FLUSH_TIMEOUT = FLUSH_CYCLES,
   parameter int CNT_W         = CNT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic [CNT_W-1:0] fifo_count,
   input  logic             fifo_full,
   input  logic             tx_active,
   input  logic             tx_done,
   output logic             fifo_wr,
   output logic             fifo_rd,
   output logic             tx_start,
   output logic [2:0]       burst_len,
   output logic             overflow_err,
   output logic [7:0]       drop_cnt,
   output logic             busy
);
   localparam int BURST_EFF = min_int(BURST, DEPTH);
   state_t     state_q, state_d;
   logic [2:0] len_q, len_d, burst_len_q, burst_len_d;
   logic       fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d, tx_start_q, tx_start_d;
   logic       overflow_err_q, overflow_err_d;
   logic [7:0] drop_cnt_q, drop_cnt_d;
   logic       tmr_en, flush_due, drop;
   assign drop   = rx_valid && fifo_full;
   assign tmr_en = state_q == IDLE && fifo_count != '0 && !rx_valid;
   flush_timer #(.MAX(FLUSH_TIMEOUT)) u_flush_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (!tmr_en),
      .en      (tmr_en),
      .expired (flush_due)
   );
   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      burst_len_d    = burst_len_q;
      fifo_rd_d      = 1'b0;
      tx_start_d     = 1'b0;
      fifo_wr_d      = rx_valid && !fifo_full;
      overflow_err_d = overflow_err_q || drop;
      drop_cnt_d     = (drop && drop_cnt_q != 8'hff) ? drop_cnt_q + 8'd1 : drop_cnt_q;
      case (state_q)
         IDLE: begin
            if (!tx_active && fifo_count >= CNT_W'(BURST_EFF)) begin
               state_d = ISSUE;
               len_d   = 3'(BURST_EFF);
            end else if (!tx_active && fifo_count != '0 && flush_due) begin
               state_d = ISSUE;
               len_d   = fifo_count[2:0];
            end
         end
         // an RX write owns the FIFO this cycle, so the pop waits a cycle
         ISSUE: begin
            if (fifo_count == '0) begin
               state_d = IDLE;
            end else if (!rx_valid) begin
               state_d     = LOAD;
               fifo_rd_d   = 1'b1;
               burst_len_d = len_q;
            end
         end
         LOAD: begin
            state_d    = WAIT_TX;
            tx_start_d = 1'b1;
         end
         WAIT_TX: state_d = tx_done ? IDLE : WAIT_TX;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         len_q          <= '0;
         burst_len_q    <= '0;
         fifo_wr_q      <= 1'b0;
         fifo_rd_q      <= 1'b0;
         tx_start_q     <= 1'b0;
         overflow_err_q <= 1'b0;
         drop_cnt_q     <= '0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         burst_len_q    <= burst_len_d;
         fifo_wr_q      <= fifo_wr_d;
         fifo_rd_q      <= fifo_rd_d;
         tx_start_q     <= tx_start_d;
         overflow_err_q <= overflow_err_d;
         drop_cnt_q     <= drop_cnt_d;
      end
   end
   assign fifo_wr      = fifo_wr_q;
   assign fifo_rd      = fifo_rd_q;
   assign tx_start     = tx_start_q;
   assign burst_len    = burst_len_q;
   assign overflow_err = overflow_err_q;
   assign drop_cnt     = drop_cnt_q;
   assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_fifo_xfer_scheduler.sv
// tb_fifo_xfer_scheduler: directed self-checking bench for fifo_xfer_scheduler
module tb_fifo_xfer_scheduler;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_valid = 1'b0;
   logic [4:0] fifo_count = '0;
   logic       fifo_full = 1'b0;
   logic       tx_active = 1'b0;
   logic       tx_done = 1'b0;
   logic       fifo_wr, fifo_rd, tx_start, overflow_err, busy;
   logic [2:0] burst_len;
   logic [7:0] drop_cnt;
   int checks = 0, passes = 0;
   int n_wr, n_rd, n_start, n_coinc;
   bit model_en = 1'b0;

   fifo_xfer_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .rx_valid     (rx_valid),
      .fifo_count   (fifo_count),
      .fifo_full    (fifo_full),
      .tx_active    (tx_active),
      .tx_done      (tx_done),
      .fifo_wr      (fifo_wr),
      .fifo_rd      (fifo_rd),
      .tx_start     (tx_start),
      .burst_len    (burst_len),
      .overflow_err (overflow_err),
      .drop_cnt     (drop_cnt),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // FIFO occupancy model: a write or pop seen this cycle shows up in fifo_count one cycle later
   task automatic tick();
      logic w, r;
      logic [2:0] l;
      w = fifo_wr;
      r = fifo_rd;
      l = burst_len;
      @(posedge clk);
      #1;
      if (fifo_wr && fifo_rd) n_coinc++;
      n_wr += int'(fifo_wr);
      n_rd += int'(fifo_rd);
      n_start += int'(tx_start);
      if (model_en) fifo_count = fifo_count + 5'(w) - (r ? 5'(l) : 5'd0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_rd(input int max, output int at);
      at = 0;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (fifo_rd) begin
            at = i;
            break;
         end
      end
   endtask

   task automatic pulse_done();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rx_valid = 1'b0;
      tx_done = 1'b0;
      tx_active = 1'b0;
      fifo_full = 1'b0;
      model_en = 1'b0;
      ticks(2);
      reset = 1'b0;
      fifo_count = '0;
      n_wr = 0;
      n_rd = 0;
      n_start = 0;
      n_coinc = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({fifo_wr, fifo_rd, tx_start, burst_len, overflow_err, drop_cnt, busy} !== 15'd0)
         $display("FAIL reset_outputs got=%b exp=0", {fifo_wr, fifo_rd, tx_start, burst_len, overflow_err, drop_cnt, busy});
      else passes++;
   endtask

   task automatic test_burst();
      int at;
      do_reset();
      model_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rx_valid = 1'b1;
         tick();
         rx_valid = 1'b0;
         checks++;
         if (fifo_wr !== 1'b1) $display("FAIL wr_latency_%0d got=%b exp=1", i, fifo_wr);
         else passes++;
         if (i < 3) ticks(9);
      end
      checks++;
      if (n_rd !== 0) $display("FAIL early_rd got=%0d exp=0", n_rd);
      else passes++;
      wait_rd(20, at);
      checks++;
      if (at !== 3) $display("FAIL burst_rd_at got=%0d exp=3", at);
      else passes++;
      checks++;
      if (burst_len !== 3'd4) $display("FAIL burst_len4 got=%0d exp=4", burst_len);
      else passes++;
      tick();
      checks++;
      if ({tx_start, fifo_rd, busy} !== 3'b101) $display("FAIL burst_start got=%b exp=101", {tx_start, fifo_rd, busy});
      else passes++;
      tx_active = 1'b1;
      ticks(20);
      checks++;
      if (n_rd !== 1 || fifo_count !== 5'd0) $display("FAIL single_rd got=%0d/%0d exp=1/0", n_rd, fifo_count);
      else passes++;
      tx_active = 1'b0;
      pulse_done();
      checks++;
      if (busy !== 1'b0 || n_wr !== 4 || n_coinc !== 0)
         $display("FAIL burst_end got=%b/%0d/%0d exp=0/4/0", busy, n_wr, n_coinc);
      else passes++;
   endtask

   task automatic test_flush();
      int at;
      do_reset();
      model_en = 1'b1;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      ticks(3);
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      wait_rd(26100, at);
      checks++;
      if (at < 26000 || at > 26005) $display("FAIL flush_rd_at got=%0d exp=26000..26005", at);
      else passes++;
      checks++;
      if (burst_len !== 3'd2) $display("FAIL flush_len got=%0d exp=2", burst_len);
      else passes++;
      tick();
      checks++;
      if (tx_start !== 1'b1) $display("FAIL flush_start got=%b exp=1", tx_start);
      else passes++;
      pulse_done();
      checks++;
      if (fifo_count !== 5'd0 || n_rd !== 1) $display("FAIL flush_drain got=%0d/%0d exp=0/1", fifo_count, n_rd);
      else passes++;
   endtask

   task automatic test_overflow();
      int at;
      do_reset();
      fifo_full = 1'b1;
      fifo_count = 5'd16;
      tx_active = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rx_valid = 1'b1;
         tick();
         rx_valid = 1'b0;
         checks++;
         if (fifo_wr !== 1'b0) $display("FAIL drop_wr_%0d got=%b exp=0", i, fifo_wr);
         else passes++;
         tick();
      end
      checks++;
      if (overflow_err !== 1'b1 || drop_cnt !== 8'd3)
         $display("FAIL drop3 got=%b/%0d exp=1/3", overflow_err, drop_cnt);
      else passes++;
      rx_valid = 1'b1;
      ticks(300);
      rx_valid = 1'b0;
      tick();
      checks++;
      if (drop_cnt !== 8'd255) $display("FAIL drop_sat got=%0d exp=255", drop_cnt);
      else passes++;
      tx_active = 1'b0;
      wait_rd(10, at);
      checks++;
      if (at == 0 || burst_len !== 3'd4) $display("FAIL full_burst got=%0d/%0d exp=found/4", at, burst_len);
      else passes++;
      fifo_full = 1'b0;
      fifo_count = 5'd12;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      checks++;
      if (fifo_wr !== 1'b1 || overflow_err !== 1'b1)
         $display("FAIL after_pop_wr got=%b/%b exp=1/1", fifo_wr, overflow_err);
      else passes++;
      fifo_count = 5'd0;
      pulse_done();
   endtask

   task automatic test_defer();
      do_reset();
      fifo_count = 5'd4;
      tick();
      checks++;
      if (busy !== 1'b1 || fifo_rd !== 1'b0) $display("FAIL defer_issue got=%b/%b exp=1/0", busy, fifo_rd);
      else passes++;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      checks++;
      if ({fifo_wr, fifo_rd} !== 2'b10) $display("FAIL defer_wr got=%b exp=10", {fifo_wr, fifo_rd});
      else passes++;
      tick();
      checks++;
      if ({fifo_wr, fifo_rd, burst_len} !== 5'b01100) $display("FAIL defer_rd got=%b exp=01100", {fifo_wr, fifo_rd, burst_len});
      else passes++;
      tick();
      checks++;
      if (tx_start !== 1'b1 || n_coinc !== 0) $display("FAIL defer_start got=%b/%0d exp=1/0", tx_start, n_coinc);
      else passes++;
      fifo_count = 5'd0;
      pulse_done();
   endtask

   task automatic test_reset_load();
      do_reset();
      fifo_count = 5'd4;
      ticks(2);
      checks++;
      if ({busy, fifo_rd} !== 2'b11) $display("FAIL load_reached got=%b exp=11", {busy, fifo_rd});
      else passes++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      fifo_count = 5'd0;
      checks++;
      if ({fifo_wr, fifo_rd, tx_start, burst_len, overflow_err, drop_cnt, busy} !== 15'd0)
         $display("FAIL load_reset got=%b exp=0", {fifo_wr, fifo_rd, tx_start, burst_len, overflow_err, drop_cnt, busy});
      else passes++;
      ticks(3);
      pulse_done();
      tick();
      checks++;
      if (n_start !== 0 || busy !== 1'b0) $display("FAIL load_abort got=%0d/%b exp=0/0", n_start, busy);
      else passes++;
   endtask

   task automatic test_back_to_back();
      int at;
      do_reset();
      model_en = 1'b1;
      fifo_count = 5'd8;
      tx_active = 1'b1;
      ticks(30);
      checks++;
      if (n_rd !== 0 || busy !== 1'b0) $display("FAIL gated_rd got=%0d/%b exp=0/0", n_rd, busy);
      else passes++;
      for (int b = 0; b < 2; b++) begin
         tx_active = 1'b0;
         wait_rd(10, at);
         checks++;
         if (at == 0 || burst_len !== 3'd4) $display("FAIL b2b_rd_%0d got=%0d/%0d exp=found/4", b, at, burst_len);
         else passes++;
         tick();
         checks++;
         if (tx_start !== 1'b1) $display("FAIL b2b_start_%0d got=%b exp=1", b, tx_start);
         else passes++;
         ticks(15);
         checks++;
         if (n_rd !== b + 1) $display("FAIL b2b_hold_%0d got=%0d exp=%0d", b, n_rd, b + 1);
         else passes++;
         pulse_done();
      end
      tick();
      checks++;
      if (fifo_count !== 5'd0 || busy !== 1'b0 || n_start !== 2)
         $display("FAIL b2b_end got=%0d/%b/%0d exp=0/0/2", fifo_count, busy, n_start);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_burst();
      test_flush();
      test_overflow();
      test_defer();
      test_reset_load();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/fifo_xfer_scheduler.md
Name: fifo_xfer_scheduler

Overview:
- Controller that sequences the 16-byte UART FIFO: turns UART RX byte strobes into FIFO write strobes, and decides when to pop a burst of 1-4 bytes and hand it to the UART TX.
- Arbitrates the FIFO between the RX writer and the TX reader; RX always wins.
- Replaces the debounced push-button clock as the FIFO/TX sequencer; everything runs on the single fast clock.

Parameters:
- DEPTH, 16, FIFO depth in bytes.
- BURST, 4, maximum bytes per TX burst.
- FLUSH_TIMEOUT, 26000, IDLE cycles with a partial FIFO before a short burst is forced (about 10 bit-times at 2600 clocks/bit).
- CNT_W, 5, width of the occupancy input; must hold DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rx_valid  in  1  1-cycle pulse from UART RX; byte is ready on the FIFO data input.
- fifo_count  in  CNT_W  current FIFO occupancy.
- fifo_full  in  1  FIFO full flag.
- tx_active  in  1  UART TX busy.
- tx_done  in  1  1-cycle pulse at the end of the TX burst.
- fifo_wr  out  1  1-cycle write strobe to the FIFO.
- fifo_rd  out  1  1-cycle burst-pop strobe to the FIFO.
- tx_start  out  1  1-cycle TX launch strobe.
- burst_len  out  3  number of bytes in the current burst (1..4); drives TX numData.
- overflow_err  out  1  sticky: an RX byte was dropped because the FIFO was full.
- drop_cnt  out  8  saturating count of dropped RX bytes.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, flush timer 0. Reset in any state aborts the burst and no tx_start is emitted. FIFO contents are the FIFO's own responsibility.
- Write path (registered, latency 1):
  - rx_valid with !fifo_full at edge N gives fifo_wr=1 for cycle N+1.
  - rx_valid with fifo_full gives no fifo_wr; overflow_err is set and drop_cnt increments, saturating at 255.
  - overflow_err clears only on reset.
- Arbitration:
  - fifo_rd is never asserted in a cycle where fifo_wr is asserted.
  - A read due in the same cycle as rx_valid is deferred 1 cycle.
  - fifo_rd is never issued when fifo_count==0.
- FSM states:
  - IDLE:
    - if fifo_count>=BURST and !tx_active, go to ISSUE with len=BURST.
    - else if fifo_count>0, flush timer==FLUSH_TIMEOUT and !tx_active, go to ISSUE with len=fifo_count.
  - ISSUE:
    - if rx_valid this cycle, stay in ISSUE (defer).
    - else pulse fifo_rd, register burst_len, go to LOAD.
  - LOAD: one cycle for FIFO data_out/numData to settle; pulse tx_start; go to WAIT_TX.
  - WAIT_TX: wait for tx_done, then go to IDLE. tx_done outside WAIT_TX is ignored.
- burst_len holds its value from the fifo_rd cycle until the next fifo_rd.
- Flush timer:
  - increments each IDLE cycle with fifo_count>0 and no rx_valid; saturates at FLUSH_TIMEOUT.
  - clears on rx_valid, on leaving IDLE, and when fifo_count==0.
- Stale count: fifo_count lags fifo_wr by 1 cycle. The resulting underestimate is accepted; a burst is never over-sized because count only grows while IDLE.
- Boundaries:
  - fifo_count==DEPTH: RX bytes drop while a 4-byte burst still proceeds; after the pop the next RX byte is accepted.
  - Pointer wrap is internal to the FIFO and transparent here.
- Timing:
  - A full burst costs 3 controller cycles (IDLE→ISSUE→LOAD) before tx_start.
  - Back-to-back bursts need tx_done between them.

Decomposition:
- Shared package fifo_uart_pkg:
  - FSM state encoding (IDLE=0, ISSUE=1, LOAD=2, WAIT_TX=3).
  - DEPTH, BURST and CNT_W constants.
  - Default CLKS_PER_BIT=2600.
- One sub-module, flush_timer: a saturating counter with clear/enable and an expired flag, reusable for a later TX watchdog.
- FSM and write path stay in the top module.

Test Plan:
- Four rx_valid pulses, 10 cycles apart, FIFO initially empty (fifo_count model follows fifo_wr) -> four fifo_wr, each 1 cycle after its rx_valid. Then one fifo_rd with burst_len=4, tx_start exactly 1 cycle later; no second fifo_rd until tx_done.
- Two RX bytes then silence -> no read before 26000 idle cycles. At expiry: fifo_rd, burst_len=2, tx_start.
- fifo_full held high, three rx_valid -> no fifo_wr, overflow_err=1, drop_cnt=3. After 300 further drops, drop_cnt stays 255.
- rx_valid on the same cycle ISSUE would pop -> fifo_wr issued, fifo_rd delayed exactly 1 cycle, never coincident with fifo_wr.
- Reset asserted in LOAD -> next cycle all outputs 0, no tx_start. A later tx_done pulse is ignored and state stays IDLE.
- tx_active high with fifo_count=8 -> no fifo_rd until tx_active falls. Then two bursts of 4, each gated by its own tx_done.
